// File: rtl/image_out_serializer_if.sv
// image_out_serializer_if: wide input beat stream plus narrow output word stream around the serializer
interface image_out_serializer_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64
);
  logic                 S_Valid;
  logic                 S_Ready;
  logic [IN_WIDTH-1:0]  S_Data;
  logic                 S_Last;
  logic                 M_Valid;
  logic                 M_Ready;
  logic [OUT_WIDTH-1:0] M_Data;
  logic                 M_Last;
  modport master (output S_Valid, S_Data, S_Last, M_Ready, input S_Ready, M_Valid, M_Data, M_Last);
  modport slave  (input S_Valid, S_Data, S_Last, M_Ready, output S_Ready, M_Valid, M_Data, M_Last);
endinterface

// File: rtl/image_out_serializer.sv
// image_out_serializer: splits wide stride-stage beats into OUT_WIDTH words, LSB first; OUT_WORD_COUNT_EN adds word counters
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
module image_out_serializer #(
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
  parameter int OUT_WIDTH               = 64,
  parameter int WIDTH_RATIO             = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic Start,
  image_out_serializer_if.slave bus,
  output logic Frame_Done,
`ifdef OUT_WORD_COUNT_EN
  output logic [31:0] Word_Count,
  output logic [31:0] Last_Frame_Words,
`endif
  output logic Err_Start_Busy
);
  localparam int IN_WIDTH = COMPUTE_CHANNEL_OUT_NUM * `WIDTH_DATA * `PICTURE_NUM;
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam logic [WIDTH_RATIO-1:0] LAST_C = WIDTH_RATIO'(RATIO - 1);
  localparam logic [WIDTH_RATIO-1:0] PEN_C = WIDTH_RATIO'(RATIO - 2);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [IN_WIDTH-1:0] held;
  logic held_last;
  logic [WIDTH_RATIO-1:0] chunk;
  logic m_valid, m_last;
  logic [OUT_WIDTH-1:0] m_data;
  logic last_c, fire, s_ready, take;
  logic [OUT_WIDTH-1:0] nxt_word;
  assign bus.S_Ready = s_ready;
  assign bus.M_Valid = m_valid;
  assign bus.M_Data = m_data;
  assign bus.M_Last = m_last;
  // Handshake decode; a new beat is taken in the same cycle the final word of the old one leaves
  always_comb begin
    last_c = chunk == LAST_C;
    fire = m_valid & bus.M_Ready;
    s_ready = !rst & (state == IDLE | (state == SEND & bus.M_Ready & last_c));
    take = bus.S_Valid & s_ready;
    nxt_word = OUT_WIDTH'(held >> (OUT_WIDTH * (int'(chunk) + 1)));
  end
  // Beat holding register, chunk walk and registered output word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      held <= '0;
      held_last <= 1'b0;
      chunk <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
      Frame_Done <= 1'b0;
      Err_Start_Busy <= 1'b0;
    end else begin
      Frame_Done <= fire & m_last;
      if (Start) Err_Start_Busy <= state == SEND;
      if (take) begin
        state <= SEND;
        held <= bus.S_Data;
        held_last <= bus.S_Last;
        chunk <= '0;
        m_valid <= 1'b1;
        m_data <= bus.S_Data[OUT_WIDTH-1:0];
        m_last <= bus.S_Last & (RATIO == 1);
      end else if (fire & !last_c) begin
        chunk <= chunk + 1'b1;
        m_data <= nxt_word;
        m_last <= held_last & (chunk == PEN_C);
      end else if (fire) begin
        state <= IDLE;
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end else if (Start & state == IDLE) begin
        chunk <= '0;
      end
    end
  end
`ifdef OUT_WORD_COUNT_EN
  // Running word count per frame; the final total is captured as the last word is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      Word_Count <= '0;
      Last_Frame_Words <= '0;
    end else if (Start & state == IDLE) begin
      Word_Count <= '0;
    end else if (fire & m_last) begin
      Word_Count <= '0;
      Last_Frame_Words <= Word_Count + 1;
    end else if (fire) begin
      Word_Count <= Word_Count + 1;
    end
  end
`endif
endmodule

// File: tb/tb_image_out_serializer.sv
// tb_image_out_serializer: table-driven vectors plus streamed frames for image_out_serializer
module tb_image_out_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic fd, err;
`ifdef OUT_WORD_COUNT_EN
  logic [31:0] wc, lfw;
`endif
  int n_cmp = 0;
  int n_err = 0;
  image_out_serializer_if #(.IN_WIDTH(128), .OUT_WIDTH(64)) bus ();
  image_out_serializer dut (
    .clk(clk), .rst(rst), .Start(start), .bus(bus.slave), .Frame_Done(fd),
`ifdef OUT_WORD_COUNT_EN
    .Word_Count(wc), .Last_Frame_Words(lfw),
`endif
    .Err_Start_Busy(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, start, sv, sl, mr;
    logic [127:0] sd;
    logic rdy, mv, ml, fd, err, cd;
    logic [63:0] md;
  } vec_t;
  vec_t vecs[$];
  localparam logic [63:0] AH = 64'h1111111111111111, AL = 64'h2222222222222222;
  localparam logic [63:0] BH = 64'hB1B1B1B1B1B1B1B1, BL = 64'hB0B0B0B0B0B0B0B0;
  localparam logic [63:0] CH = 64'hC1C1C1C1C1C1C1C1, CL = 64'hC0C0C0C0C0C0C0C0;
  localparam logic [63:0] DH = 64'hD1D1D1D1D1D1D1D1, DL = 64'hD0D0D0D0D0D0D0D0;
  localparam logic [63:0] EH = 64'hE1E1E1E1E1E1E1E1, EL = 64'hE0E0E0E0E0E0E0E0;
  function automatic vec_t mk(logic r, logic st, logic sv, logic [127:0] sd, logic sl, logic mr,
                              logic rdy, logic mv, logic [63:0] md, logic ml, logic f, logic e, logic cd);
    vec_t v;
    v.rst = r; v.start = st; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.rdy = rdy; v.mv = mv; v.md = md; v.ml = ml; v.fd = f; v.err = e; v.cd = cd;
    return v;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] word(int base, int k);
    return 64'hC0DE_0000_0000_0000 | 64'(base + k);
  endfunction
  task automatic run_frame(input int n, input bit tog, input int base);
    int idx = 0;
    int w = 0;
    int cyc = 0;
    int early_fd = 0;
    bit stalled = 0;
    bit mr;
    logic [63:0] pd = '0;
    while (w < 2 * n && cyc < 400) begin
      mr = tog ? (cyc % 2 == 0) : 1'b1;
      bus.S_Valid = idx < n;
      bus.S_Data = {word(base, 2 * idx + 1), word(base, 2 * idx)};
      bus.S_Last = idx == n - 1;
      bus.M_Ready = mr;
      #1;
      if (fd) early_fd++;
      if (stalled) begin
        chk("stall_valid", bus.M_Valid, 1);
        chk("stall_data", bus.M_Data, pd);
      end
      if (!tog && w > 0) chk("no_bubble", bus.M_Valid, 1);
      if (!tog && bus.M_Valid) chk("ready_cadence", bus.S_Ready, w % 2 == 1);
      if (bus.M_Valid && mr) begin
        chk("word", bus.M_Data, word(base, w));
        chk("word_last", bus.M_Last, w == 2 * n - 1);
        w++;
      end
      stalled = bus.M_Valid & !mr;
      pd = bus.M_Data;
      if (bus.S_Valid & bus.S_Ready) idx++;
      cyc++;
      @(negedge clk);
    end
    bus.S_Valid = 1'b0;
    bus.M_Ready = 1'b1;
    chk("frame_words", w, 2 * n);
    chk("frame_beats", idx, n);
    chk("early_frame_done", early_fd, 0);
    chk("frame_done", fd, 1);
    chk("idle_after_frame", bus.M_Valid, 0);
`ifdef OUT_WORD_COUNT_EN
    chk("last_frame_words", lfw, 2 * n);
    chk("word_count_cleared", wc, 0);
`endif
    @(negedge clk);
    chk("frame_done_pulse", fd, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.S_Valid = 1'b0; bus.S_Data = '0; bus.S_Last = 1'b0; bus.M_Ready = 1'b0;
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, {AH, AL}, 1, 1, 1, 1, AL, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, AH, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, {BH, BL}, 0, 1, 1, 1, BL, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, BL, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, BH, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, {CH, CL}, 1, 0, 0, 1, BH, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, {CH, CL}, 1, 1, 1, 1, CL, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, CH, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, {DH, DL}, 0, 1, 1, 1, DL, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, {EH, EL}, 1, 1, 0, 1, DH, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, {EH, EL}, 1, 1, 1, 1, EL, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, EH, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, {AH, AL}, 1, 1, 1, 1, AL, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, AH, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start;
      bus.S_Valid = vecs[i].sv; bus.S_Data = vecs[i].sd; bus.S_Last = vecs[i].sl; bus.M_Ready = vecs[i].mr;
      #1;
      chk($sformatf("v%0d_s_ready", i), bus.S_Ready, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_m_valid", i), bus.M_Valid, vecs[i].mv);
      chk($sformatf("v%0d_m_last", i), bus.M_Last, vecs[i].ml);
      chk($sformatf("v%0d_frame_done", i), fd, vecs[i].fd);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      if (vecs[i].cd) chk($sformatf("v%0d_m_data", i), bus.M_Data, vecs[i].md);
    end
    rst = 1'b0; start = 1'b0; bus.S_Valid = 1'b0; bus.M_Ready = 1'b1;
    @(negedge clk);
    run_frame(16, 1'b0, 32'h100);
    run_frame(4, 1'b1, 32'h200);
    run_frame(3, 1'b0, 32'h300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
